// File: rtl/scan_test_ctrl_if.sv
// Control/status bundle between a test master and the scan-test sequencer.
interface scan_test_ctrl_if #(
  parameter int CHAIN_LEN = 2
);
  logic                 start;
  logic                 abort;
  logic [CHAIN_LEN-1:0] pattern_in;
  logic [CHAIN_LEN-1:0] expect_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CHAIN_LEN-1:0] captured;

  modport master (
    output start, abort, pattern_in, expect_in,
    input  busy, done, pass, captured
  );

  modport slave (
    input  start, abort, pattern_in, expect_in,
    output busy, done, pass, captured
  );
endinterface

// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: loads a stimulus into the chain, pulses functional
// capture, unloads the response and compares it against the expected vector.
module scan_test_ctrl #(
  parameter int CHAIN_LEN   = 2,
  parameter int CAPTURE_CYC = 1,
  parameter int CNT_W       = $clog2(CHAIN_LEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  scan_test_ctrl_if.slave ctrl,
  input  logic            scan_out_i,
  output logic            scan_en_o,
  output logic            scan_in_o
);

  // The one down-counter also times CAPTURE, which may need more bits than CHAIN_LEN.
  localparam int CAP_W = $clog2(CAPTURE_CYC + 1);
  localparam int CW    = (CNT_W > CAP_W) ? CNT_W : CAP_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_UNLOAD  = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;

  localparam logic [CW-1:0] LEN_CNT = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] CAP_CNT = CW'(CAPTURE_CYC);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] shift_q, shift_d;
  logic [CHAIN_LEN-1:0] expect_q, expect_d;
  logic [CHAIN_LEN-1:0] captured_q, captured_d;
  logic                 pass_q, pass_d;
  logic [CHAIN_LEN-1:0] unload_next;
  logic                 last;

  assign last        = (cnt_q == ONE);
  assign unload_next = (shift_q << 1) | CHAIN_LEN'(scan_out_i);

  // One shift register serves both directions: MSB-first out during LOAD,
  // scan_out filled in at the LSB during UNLOAD so the first sample ends at the MSB.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    expect_d   = expect_q;
    captured_d = captured_q;
    pass_d     = pass_q;
    if (ctrl.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl.start && !ctrl.abort) begin
            state_d    = S_LOAD;
            cnt_d      = LEN_CNT;
            shift_d    = ctrl.pattern_in;
            expect_d   = ctrl.expect_in;
            captured_d = '0;
            pass_d     = 1'b0;
          end
        end
        S_LOAD: begin
          shift_d = shift_q << 1;
          if (last) begin
            state_d = S_CAPTURE;
            cnt_d   = CAP_CNT;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        S_CAPTURE: begin
          if (last) begin
            state_d = S_UNLOAD;
            cnt_d   = LEN_CNT;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        S_UNLOAD: begin
          shift_d = unload_next;
          if (last) begin
            state_d    = S_REPORT;
            cnt_d      = ONE;
            captured_d = unload_next;
            pass_d     = (unload_next == expect_q);
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        S_REPORT: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      expect_q   <= '0;
      captured_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      expect_q   <= expect_d;
      captured_q <= captured_d;
      pass_q     <= pass_d;
    end
  end

  assign scan_en_o     = (state_q == S_LOAD) || (state_q == S_UNLOAD);
  assign scan_in_o     = (state_q == S_LOAD) && shift_q[CHAIN_LEN-1];
  assign ctrl.busy     = (state_q != S_IDLE);
  assign ctrl.done     = (state_q == S_REPORT);
  assign ctrl.pass     = pass_q;
  assign ctrl.captured = captured_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: two instances (CAPTURE_CYC 1 and 3), each driving a
// two-cell chain model, checked against a per-test capture model.
module tb_scan_test_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic fi;
  logic sel;
  int   checks = 0;
  int   errors = 0;
  int   testId = 0;

  always #5 clk = ~clk;

  scan_test_ctrl_if #(.CHAIN_LEN(2)) bus1 ();
  scan_test_ctrl_if #(.CHAIN_LEN(2)) bus3 ();

  logic       sen1, sin1, sout1;
  logic       sen3, sin3, sout3;
  logic [1:0] chainA = 2'b00;
  logic [1:0] chainB = 2'b00;

  scan_test_ctrl #(.CHAIN_LEN(2), .CAPTURE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ctrl(bus1),
    .scan_out_i(sout1), .scan_en_o(sen1), .scan_in_o(sin1)
  );

  scan_test_ctrl #(.CHAIN_LEN(2), .CAPTURE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ctrl(bus3),
    .scan_out_i(sout3), .scan_en_o(sen3), .scan_in_o(sin3)
  );

  // Chain model, bit k = cell k: shift moves scan_in into cell 0, capture
  // loads fi into cell 0 and the inverse of cell 0 into cell 1.
  always @(posedge clk) begin
    if (sen1) chainA <= {chainA[0], sin1};
    else      chainA <= {~chainA[0], fi};
    if (sen3) chainB <= {chainB[0], sin3};
    else      chainB <= {~chainB[0], fi};
  end
  assign sout1 = chainA[1];
  assign sout3 = chainB[1];

  logic       mSen, mSin, mBusy, mDone, mPass;
  logic [1:0] mCaptured, mCells;
  assign mSen      = sel ? sen3 : sen1;
  assign mSin      = sel ? sin3 : sin1;
  assign mBusy     = sel ? bus3.busy : bus1.busy;
  assign mDone     = sel ? bus3.done : bus1.done;
  assign mPass     = sel ? bus3.pass : bus1.pass;
  assign mCaptured = sel ? bus3.captured : bus1.captured;
  assign mCells    = sel ? chainB : chainA;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(logic st, logic ab, logic [1:0] pat, logic [1:0] exp);
    if (sel) begin
      bus3.start = st; bus3.abort = ab; bus3.pattern_in = pat; bus3.expect_in = exp;
    end else begin
      bus1.start = st; bus1.abort = ab; bus1.pattern_in = pat; bus1.expect_in = exp;
    end
  endtask

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cell contents after load are the pattern; each capture cycle applies the chain's functional rule.
  function automatic logic [1:0] modelCapture(logic [1:0] pat, logic f, int capCyc);
    logic [1:0] cells;
    cells = pat;
    for (int i = 0; i < capCyc; i++) cells = {~cells[0], f};
    return cells;
  endfunction

  task automatic applyStimulus(logic [1:0] pat, logic [1:0] exp, logic f, int capCyc,
                               int abortCyc, bit holdStart);
    int         total;
    logic [1:0] expCap;
    bit         aborted;
    logic       expEn, expIn;
    total   = 2 * 2 + capCyc + 1;
    expCap  = modelCapture(pat, f, capCyc);
    aborted = 1'b0;
    testId++;
    fi = f;
    setIn(1'b1, 1'b0, pat, exp);
    tick();
    for (int cyc = 1; cyc <= total; cyc++) begin
      setIn(holdStart, (cyc == abortCyc), ~pat, ~exp);
      expEn = !aborted && ((cyc <= 2) || ((cyc > 2 + capCyc) && (cyc <= 4 + capCyc)));
      expIn = aborted ? 1'b0 : (cyc == 1) ? pat[1] : (cyc == 2) ? pat[0] : 1'b0;
      checkOutput($sformatf("T%0d scan_en c%0d", testId, cyc), 32'(mSen), 32'(expEn));
      checkOutput($sformatf("T%0d scan_in c%0d", testId, cyc), 32'(mSin), 32'(expIn));
      checkOutput($sformatf("T%0d busy c%0d", testId, cyc), 32'(mBusy), 32'(!aborted));
      checkOutput($sformatf("T%0d done c%0d", testId, cyc), 32'(mDone),
                  32'(!aborted && (cyc == total)));
      if (cyc == 1) begin
        checkOutput($sformatf("T%0d cleared captured", testId), 32'(mCaptured), 32'd0);
        checkOutput($sformatf("T%0d cleared pass", testId), 32'(mPass), 32'd0);
      end
      if (cyc == 3 && !aborted)
        checkOutput($sformatf("T%0d chain after load", testId), 32'(mCells), 32'(pat));
      tick();
      if (cyc == abortCyc) aborted = 1'b1;
    end
    setIn(holdStart, 1'b0, ~pat, ~exp);
    checkOutput($sformatf("T%0d idle busy", testId), 32'(mBusy), 32'd0);
    checkOutput($sformatf("T%0d idle done", testId), 32'(mDone), 32'd0);
    checkOutput($sformatf("T%0d captured", testId), 32'(mCaptured),
                32'(aborted ? 2'b00 : expCap));
    checkOutput($sformatf("T%0d pass", testId), 32'(mPass),
                32'(!aborted && (expCap == exp)));
    if (holdStart) begin
      tick();
      checkOutput($sformatf("T%0d restart from idle", testId), 32'(mBusy), 32'd1);
      setIn(1'b0, 1'b1, pat, exp);
      tick();
      setIn(1'b0, 1'b0, pat, exp);
      checkOutput($sformatf("T%0d restart aborted", testId), 32'(mBusy), 32'd0);
    end
    tick();
  endtask

  initial begin
    logic [1:0] p, e;
    logic       f;
    int         c;
    sel = 1'b0; fi = 1'b0; rst_n = 1'b1;
    bus1.start = 0; bus1.abort = 0; bus1.pattern_in = 0; bus1.expect_in = 0;
    bus3.start = 0; bus3.abort = 0; bus3.pattern_in = 0; bus3.expect_in = 0;
    #1 rst_n = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rst scan_en", 32'(sen1), 32'd0);
    checkOutput("rst scan_in", 32'(sin1), 32'd0);
    checkOutput("rst busy", 32'(bus1.busy), 32'd0);
    checkOutput("rst done", 32'(bus1.done), 32'd0);
    checkOutput("rst pass", 32'(bus1.pass), 32'd0);
    checkOutput("rst captured", 32'(bus1.captured), 32'd0);
    checkOutput("rst busy dut3", 32'(bus3.busy), 32'd0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    $display("[TB] directed tests, CAPTURE_CYC=1");
    applyStimulus(2'b00, 2'b10, 1'b0, 1, 0, 1'b0);

    setIn(1'b1, 1'b0, 2'b11, 2'b00);
    tick();
    setIn(1'b0, 1'b0, 2'b11, 2'b00);
    tick();
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midload rst scan_en", 32'(sen1), 32'd0);
    checkOutput("midload rst scan_in", 32'(sin1), 32'd0);
    checkOutput("midload rst busy", 32'(bus1.busy), 32'd0);
    checkOutput("midload rst pass", 32'(bus1.pass), 32'd0);
    checkOutput("midload rst captured", 32'(bus1.captured), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("post rst busy %0d", i), 32'(bus1.busy), 32'd0);
      checkOutput($sformatf("post rst done %0d", i), 32'(bus1.done), 32'd0);
    end

    applyStimulus(2'b01, 2'b11, 1'b1, 1, 0, 1'b0);
    applyStimulus(2'b10, 2'b10, 1'b0, 1, 0, 1'b0);
    applyStimulus(2'b10, 2'b10, 1'b0, 1, 5, 1'b0);
    applyStimulus(2'b11, 2'b00, 1'b1, 1, 0, 1'b1);

    $display("[TB] IDLE start with abort is refused");
    setIn(1'b1, 1'b1, 2'b01, 2'b01);
    tick();
    setIn(1'b0, 1'b0, 2'b01, 2'b01);
    checkOutput("start+abort idle busy", 32'(bus1.busy), 32'd0);
    tick();

    $display("[TB] directed test, CAPTURE_CYC=3");
    sel = 1'b1;
    applyStimulus(2'b11, 2'b10, 1'b0, 3, 0, 1'b0);
    applyStimulus(2'b01, 2'b01, 1'b1, 3, 0, 1'b1);

    $display("[TB] randomized tests");
    for (int i = 0; i < 16; i++) begin
      sel = 1'($urandom_range(0, 1));
      p   = 2'($urandom_range(0, 3));
      f   = 1'($urandom_range(0, 1));
      c   = sel ? 3 : 1;
      e   = ($urandom_range(0, 1) == 1) ? modelCapture(p, f, c) : 2'($urandom_range(0, 3));
      applyStimulus(p, e, f, c, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
